cpu_test_runner: RTL and testbench
==================================

Name: cpu_test_runner

Overview:
On-chip regression harness for the CHIP-8 core; the synthesizable successor of the simulation bench flow (clear, load, run, check). It clears the whole program memory, streams a program in at LOAD_BASE, releases the CPU until it reports idle or a cycle budget expires, then checks an address range against an expected byte. The ADDR_WIDTH-wide memory port is driven through an external mux selected by mem_own.

Parameters:
ADDR_WIDTH, 12, memory address width; memory depth is 2**ADDR_WIDTH.
DATA_WIDTH, 8, memory word width.
LOAD_BASE, 'h200, address of the first program byte.
TIMEOUT_WIDTH, 20, width of the run-cycle counter; the budget is 2**TIMEOUT_WIDTH-1 cycles.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a run; ignored while busy.
check_lo  in  ADDR_WIDTH  first address to check; latched on start.
check_hi  in  ADDR_WIDTH  last address to check, inclusive; latched on start.
expected  in  DATA_WIDTH  required value of every checked byte; latched on start.
prog_valid  in  1  program byte available.
prog_data  in  DATA_WIDTH  program byte.
prog_last  in  1  marks the final program byte.
prog_ready  out  1  harness accepts a byte (LOAD state only).
mem_own  out  1  harness owns the memory port.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  write data.
mem_we  out  1  write enable.
mem_rdata  in  DATA_WIDTH  read data, valid one cycle after mem_addr.
cpu_reset  out  1  holds the CPU in reset.
cpu_idle  in  1  CPU has reached its idle state.
busy  out  1  run in progress.
done  out  1  run finished; held until the next accepted start.
pass  out  1  valid when done.
timeout  out  1  run ended by the cycle budget.
fail_addr  out  ADDR_WIDTH  first mismatching address.
fail_data  out  DATA_WIDTH  data read at fail_addr.

Behaviour:
- Reset, synchronous and taking priority over everything including a run in progress: state IDLE; cpu_reset=1; every other output 0.
- States: IDLE, CLEAR, LOAD, RUN, CHK_RD, CHK_CMP, DONE.
- IDLE: on start, latch check_lo/check_hi/expected; clear done, pass, timeout, fail_addr, fail_data; go to CLEAR. busy=1 in every state except IDLE and DONE.
- CLEAR: mem_own=1, mem_we=1, mem_wdata=0, mem_addr counts 0 up to 2**ADDR_WIDTH-1, one write per cycle; after the top address go to LOAD. Duration is exactly 2**ADDR_WIDTH cycles.
- LOAD: prog_ready=1 and mem_own=1. Each cycle with prog_valid&&prog_ready writes prog_data at LOAD_BASE+n, where n is the count of bytes accepted so far. Go to RUN after the byte carrying prog_last is accepted, or after a byte is written to the top address, whichever comes first; no wrap-around. No timeout in LOAD.
- RUN: cpu_reset=0, mem_own=0, mem_we=0. The cycle counter starts at 0 and increments every cycle. cpu_idle is ignored on the first RUN cycle.
  - If cpu_idle=1 (from the second cycle onward): go to CHK_RD, or to DONE with pass=1 if latched lo>hi.
  - Else if the counter reaches all-ones: go to DONE with timeout=1, pass=0.
  - If both occur on the same cycle, idle wins.
- CHK_RD: cpu_reset=1, mem_own=1, mem_we=0, mem_addr=current pointer (starts at check_lo).
- CHK_CMP: compare mem_rdata with expected.
  - Mismatch: fail_addr=pointer, fail_data=mem_rdata, pass=0, go to DONE.
  - Match and pointer==check_hi: pass=1, go to DONE.
  - Otherwise increment the pointer and return to CHK_RD. Each byte costs 2 cycles.
- cpu_reset=1 in all states except RUN.
- DONE: done=1, mem_own=0, cpu_reset=1. Results are stable until the next start, which returns to the IDLE-on-start behaviour (enters CLEAR on the next cycle).
- mem_we is never high in RUN, CHK_RD, CHK_CMP, IDLE or DONE.

Test Plan:
1. Program 6042 A020 F055 00FD ... with check 020..020, expected 42 -> 4096 clear writes, program bytes at 200+, done=1, pass=1, timeout=0.
2. Same program with expected 43 -> pass=0, fail_addr=020, fail_data=42.
3. Screen-clear program with check 100..1FF, expected 00 -> 256 reads, pass=1; poke 05 at 180 mid-run via the CPU -> fail_addr=180, fail_data=05.
4. CPU that never raises cpu_idle, TIMEOUT_WIDTH=4 -> done after exactly 15 RUN cycles, timeout=1, pass=0, no CHK reads.
5. prog_valid toggled every other cycle, with start pulses during LOAD -> bytes land contiguously from 200, starts ignored; stream of 0xE01 bytes -> last written at FFF, prog_ready drops, RUN entered.
6. reset asserted mid-CLEAR at address 0x300 -> next cycle state IDLE, cpu_reset=1, mem_we=0, busy=0; a fresh start re-clears from 000. Also cover check_lo=10, check_hi=05 -> pass=1 with no reads.

Source files
------------

// File: rtl/cpu_test_runner.sv
// cpu_test_runner: on-chip regression harness for the CHIP-8 core.
// Runs one test in four phases. It first clears the whole program memory.
// It then streams a program in at LOAD_BASE, lets the CPU run until it
// reports idle or the cycle budget expires, and finally checks an address
// range against a single expected byte. While the harness owns the memory
// port (mem_own=1), the external mux routes mem_addr/mem_we/mem_wdata to
// the RAM.

module cpu_test_runner #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE     = 'h200,
  parameter int                    TIMEOUT_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] check_lo,
  input  logic [ADDR_WIDTH-1:0] check_hi,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  mem_own,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_reset,
  input  logic                  cpu_idle,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_CHK_RD,
    S_CHK_CMP,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;
  // The run ends once the counter would reach all-ones, giving a budget of
  // 2**TIMEOUT_WIDTH-1 RUN cycles (counter values 0 .. all-ones minus one).
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    ptr;      // clear address, load address or check pointer
  logic [TIMEOUT_WIDTH-1:0] cnt;      // RUN cycle counter; zero on the first RUN cycle
  logic [ADDR_WIDTH-1:0]    lo_q;
  logic [ADDR_WIDTH-1:0]    hi_q;
  logic [DATA_WIDTH-1:0]    exp_q;

  // Memory-port and CPU-control outputs decoded from the current phase.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    prog_ready = 1'b0;
    mem_own    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    cpu_reset  = 1'b1;
    busy       = 1'b1;
    unique case (state)
      S_IDLE, S_DONE: busy = 1'b0;
      S_CLEAR: begin
        mem_own  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ptr;
      end
      S_LOAD: begin
        // The write happens in the same cycle as the handshake so the last
        // byte lands before RUN, where the harness no longer owns memory.
        prog_ready = 1'b1;
        mem_own    = 1'b1;
        mem_addr   = ptr;
        mem_we     = prog_valid;
        mem_wdata  = prog_data;
      end
      S_RUN: cpu_reset = 1'b0;
      S_CHK_RD, S_CHK_CMP: begin
        mem_own  = 1'b1;
        mem_addr = ptr;
      end
      default: busy = 1'b0;
    endcase
  end

  // Phase sequencing, address/cycle counting and the latched result.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the values from the start of the cycle.
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      exp_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lo_q      <= check_lo;
            hi_q      <= check_hi;
            exp_q     <= expected;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            ptr       <= '0;
            state     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (ptr == ADDR_TOP) begin
            ptr   <= LOAD_BASE;
            state <= S_LOAD;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        S_LOAD: begin
          if (prog_valid) begin
            // Stop at the top address rather than wrapping onto low memory.
            if (prog_last || ptr == ADDR_TOP) begin
              cnt   <= '0;
              state <= S_RUN;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end

        S_RUN: begin
          cnt <= cnt + 1'b1;
          // cpu_idle may still reflect the pre-reset CPU on the first cycle,
          // so it is only trusted once the counter has moved. Idle is tested
          // first so it wins over an expiring budget.
          if (cnt != '0 && cpu_idle) begin
            if (lo_q > hi_q) begin
              pass  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ptr   <= lo_q;
              state <= S_CHK_RD;
            end
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_CHK_RD: state <= S_CHK_CMP;

        S_CHK_CMP: begin
          if (mem_rdata != exp_q) begin
            fail_addr <= ptr;
            fail_data <= mem_rdata;
            pass      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ptr == hi_q) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= S_CHK_RD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_test_runner.sv
// Testbench for cpu_test_runner. It models the RAM behind the memory mux
// and a stand-in CPU that can poke one byte and then go idle after a chosen
// delay. A reference model predicts each run's outcome from the program,
// the check window and the CPU behaviour. The monitor compares those
// predictions, together with the observed clear, load, RUN and check
// activity, whenever done rises.

module tb_cpu_test_runner;

  localparam int AW         = 12;
  localparam int DW         = 8;
  localparam int TW         = 4;
  localparam int DEPTH      = 1 << AW;
  localparam int LOAD_BASE  = 'h200;
  localparam int RUN_BUDGET = (1 << TW) - 1;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [11:0] fail_addr;
    logic [7:0]  fail_data;
    int          run_cycles;
    int          chk_cycles;
    int          load_cnt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] check_lo;
  logic [AW-1:0] check_hi;
  logic [DW-1:0] expected;
  logic          prog_valid;
  logic [DW-1:0] prog_data;
  logic          prog_last;
  logic          prog_ready;
  logic          mem_own;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          cpu_reset;
  logic          cpu_idle;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  cpu_test_runner #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .LOAD_BASE    (12'h200),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .check_lo  (check_lo),
    .check_hi  (check_hi),
    .expected  (expected),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .prog_ready(prog_ready),
    .mem_own   (mem_own),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_reset (cpu_reset),
    .cpu_idle  (cpu_idle),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  // Test configuration shared by stimulus, CPU model and monitor.
  byte_t       cur_prog[$];
  int          cpu_delay;
  bit          cpu_never;
  bit          cpu_poke;
  logic [11:0] cpu_addr;
  byte_t       cpu_wdata;
  logic        cpu_we;
  exp_t        sb_q[$];
  int          n_cmp;
  int          n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM behind the external mux; read data appears one cycle after the address.
  byte_t mem [DEPTH];
  always @(posedge clk) begin
    if (mem_own && mem_we) mem[mem_addr] <= mem_wdata;
    else if (!mem_own && cpu_we) mem[cpu_addr] <= cpu_wdata;
    mem_rdata <= mem[mem_own ? mem_addr : cpu_addr];
  end

  // Stand-in CPU: counts cycles out of reset. It pokes one byte on its
  // first cycle (if enabled) and reports idle from cycle cpu_delay onward.
  int cpu_rc;
  bit cpu_in_run;
  initial begin
    cpu_rc     = 0;
    cpu_in_run = 1'b0;
    cpu_idle   = 1'b0;
    cpu_we     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!cpu_reset) begin
        cpu_rc     = cpu_in_run ? cpu_rc + 1 : 0;
        cpu_in_run = 1'b1;
      end else begin
        cpu_rc     = 0;
        cpu_in_run = 1'b0;
      end
      cpu_idle = !cpu_reset && !cpu_never && (cpu_rc >= cpu_delay);
      cpu_we   = !cpu_reset && cpu_poke && (cpu_rc == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected memory image after clear, load and CPU poke,
  // then the outcome of idle vs. budget and of the range scan.
  function automatic exp_t model(input int lo, input int hi, input byte_t expv);
    byte_t img [DEPTH];
    exp_t  e;
    int    n;
    int    idle_at;
    e = '0;
    foreach (img[i]) img[i] = 8'h00;
    n = (cur_prog.size() < DEPTH - LOAD_BASE) ? cur_prog.size() : DEPTH - LOAD_BASE;
    for (int i = 0; i < n; i++) img[LOAD_BASE + i] = cur_prog[i];
    e.load_cnt = n;
    idle_at = (cpu_delay < 1) ? 1 : cpu_delay;
    if (cpu_never || idle_at > RUN_BUDGET - 1) begin
      e.timeout    = 1'b1;
      e.run_cycles = RUN_BUDGET;
      return e;
    end
    e.run_cycles = idle_at + 1;
    if (cpu_poke) img[cpu_addr] = cpu_wdata;
    e.pass = 1'b1;
    if (lo > hi) return e;
    for (int a = lo; a <= hi; a++) begin
      e.chk_cycles += 2;
      if (img[a] !== expv) begin
        e.pass      = 1'b0;
        e.fail_addr = 12'(a);
        e.fail_data = img[a];
        break;
      end
    end
    return e;
  endfunction

  // Monitor: tallies memory-port activity per run and scores on done rising.
  int   clr_cnt, clr_err, load_cnt, load_err, run_cyc, chk_cyc, stray_we;
  bit   busy_q, done_q;
  exp_t got_e;
  initial begin
    busy_q = 1'b0;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !busy_q) begin
        clr_cnt = 0; clr_err = 0; load_cnt = 0; load_err = 0;
        run_cyc = 0; chk_cyc = 0; stray_we = 0;
      end
      if (mem_we) begin
        if (!mem_own || !busy) begin
          stray_we++;
        end else if (prog_ready) begin
          if (load_cnt >= cur_prog.size() || int'(mem_addr) != LOAD_BASE + load_cnt ||
              mem_wdata !== cur_prog[load_cnt])
            load_err++;
          load_cnt++;
        end else begin
          if (int'(mem_addr) != clr_cnt || mem_wdata !== 8'h00) clr_err++;
          clr_cnt++;
        end
      end
      if (!cpu_reset) run_cyc++;
      if (busy && mem_own && !mem_we && !prog_ready) chk_cyc++;
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done rose with no run outstanding");
        end else begin
          got_e = sb_q.pop_front();
          check("pass",       pass,      got_e.pass);
          check("timeout",    timeout,   got_e.timeout);
          check("fail_addr",  fail_addr, got_e.fail_addr);
          check("fail_data",  fail_data, got_e.fail_data);
          check("run_cycles", run_cyc,   got_e.run_cycles);
          check("chk_cycles", chk_cyc,   got_e.chk_cycles);
          check("load_cnt",   load_cnt,  got_e.load_cnt);
          check("load_err",   load_err,  0);
          check("clear_cnt",  clr_cnt,   DEPTH);
          check("clear_err",  clr_err,   0);
          check("stray_we",   stray_we,  0);
        end
      end
      busy_q = busy;
      done_q = done;
    end
  end

  // One full run: predict, start, stream the program, wait for done.
  task automatic run_test(input string tag, input int lo, input int hi, input byte_t expv,
                          input bit toggle, input bit spam);
    exp_t e;
    int   sent;
    int   guard;
    int   n;
    bit   seen_ready;
    e = model(lo, hi, expv);
    sb_q.push_back(e);
    n = cur_prog.size();
    check_lo = lo[11:0];
    check_hi = hi[11:0];
    expected = expv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    sent       = 0;
    guard      = 0;
    seen_ready = 1'b0;
    while (sent < n && guard < 16000) begin
      prog_valid = toggle ? (guard % 2 == 0) : 1'b1;
      prog_data  = cur_prog[sent];
      prog_last  = (sent == n - 1);
      if (spam && seen_ready && (guard % 3 == 0)) begin
        start    = 1'b1;
        check_lo = 12'($urandom_range(0, 4095));
        check_hi = 12'($urandom_range(0, 4095));
        expected = byte_t'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (prog_ready) seen_ready = 1'b1;
      else if (seen_ready) break;
      if (prog_valid && prog_ready) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    start      = 1'b0;
    check({tag, "_accepted"}, sent, e.load_cnt);
    guard = 0;
    while (!done && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (!done) sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_held"}, done, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_done_cpurst"}, cpu_reset, 1);
    check({tag, "_done_own"}, mem_own, 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    check_lo   = '0;
    check_hi   = '0;
    expected   = '0;
    prog_valid = 1'b0;
    prog_data  = '0;
    prog_last  = 1'b0;
    cpu_delay  = 5;
    cpu_never  = 1'b0;
    cpu_poke   = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset",  cpu_reset,  1);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_mem_own",    mem_own,    0);
    check("rst_mem_we",     mem_we,     0);
    check("rst_prog_ready", prog_ready, 0);
    reset = 1'b0;

    // Store-V0 program; the CPU writes 42 at 020 while running.
    cur_prog = '{8'h60, 8'h42, 8'hA0, 8'h20, 8'hF0, 8'h55, 8'h00, 8'hFD};
    cpu_delay = 5; cpu_poke = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h42;
    run_test("t1", 'h020, 'h020, 8'h42, 1'b0, 1'b0);
    run_test("t2", 'h020, 'h020, 8'h43, 1'b0, 1'b0);

    // Screen-clear program: 256 zero bytes, then the same with a poke at 180.
    cur_prog = '{8'h00, 8'hE0, 8'h12, 8'h02};
    cpu_delay = 7; cpu_poke = 1'b0;
    run_test("t3", 'h100, 'h1FF, 8'h00, 1'b0, 1'b0);
    cpu_poke = 1'b1; cpu_addr = 12'h180; cpu_wdata = 8'h05;
    run_test("t3p", 'h100, 'h1FF, 8'h00, 1'b0, 1'b0);

    // CPU that never goes idle; then idle on the last budget cycle; then
    // idle asserted from the very first RUN cycle.
    cpu_poke = 1'b0; cpu_never = 1'b1;
    run_test("t4", 'h200, 'h203, 8'h00, 1'b0, 1'b0);
    cpu_never = 1'b0; cpu_delay = RUN_BUDGET - 1;
    run_test("t4b", 'h200, 'h200, 8'h00, 1'b0, 1'b0);
    cpu_delay = 0;
    run_test("t4c", 'h200, 'h201, 8'h00, 1'b0, 1'b0);

    // Throttled stream with stray starts during LOAD; byte 214 stays clear.
    cur_prog.delete();
    repeat (20) cur_prog.push_back(8'h5A);
    cpu_delay = 4;
    run_test("t5", 'h200, 'h214, 8'h5A, 1'b1, 1'b1);

    // Over-long stream: only E00 bytes fit, the last at FFF.
    cur_prog.delete();
    for (int i = 0; i < 'hE01; i++) cur_prog.push_back(8'h77);
    run_test("t5b", 'hFF0, 'hFFF, 8'h77, 1'b0, 1'b0);

    // Reset in the middle of CLEAR.
    cur_prog = '{8'h12, 8'h00};
    check_lo = '0; check_hi = '0; expected = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!(mem_we && mem_addr == 12'h300) && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst_mid_at_300", mem_addr, 'h300);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy",      busy,      0);
    check("rst_mid_mem_we",    mem_we,    0);
    check("rst_mid_cpu_reset", cpu_reset, 1);
    check("rst_mid_mem_own",   mem_own,   0);
    check("rst_mid_done",      done,      0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fresh run after the abort, with an empty (lo > hi) window.
    cpu_delay = 3;
    run_test("t6", 'h010, 'h005, 8'hAA, 1'b0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 3; r++) begin
      int len;
      int lo;
      int hi;
      byte_t ev;
      cur_prog.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) cur_prog.push_back(byte_t'($urandom_range(0, 255)));
      lo        = 'h1F8 + int'($urandom_range(0, 40));
      hi        = lo + int'($urandom_range(0, 20)) - 3;
      cpu_delay = $urandom_range(0, 17);
      cpu_poke  = 1'($urandom_range(0, 1));
      cpu_addr  = 12'(lo + int'($urandom_range(0, 6)));
      cpu_wdata = byte_t'($urandom_range(0, 255));
      ev        = ($urandom_range(0, 1) == 1) ? cur_prog[0] : 8'h00;
      run_test($sformatf("rnd%0d", r), lo, hi, ev, 1'($urandom_range(0, 1)), 1'b0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
